// File: rtl/div_rem_4_bit.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Start/done handshake; divide-by-zero is resolved immediately without entering CALC.
module div_rem_4_bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [4:0]  partial_rem;
    logic [7:0]  shift_dvd;
    logic [2:0]  count;
    logic [3:0]  divisor_r;

    logic        accept;
    logic [5:0]  trial;
    logic        qbit;
    logic [4:0]  step_rem;

    // One restoring step; partial_rem stays below divisor, so bit 5 of trial is the borrow.
    always_comb begin
        trial    = {partial_rem, shift_dvd[7]} - {2'b00, divisor_r};
        qbit     = ~trial[5];
        step_rem = qbit ? trial[4:0] : {partial_rem[3:0], shift_dvd[7]};
    end

    always_comb begin
        accept     = start && (state == IDLE || state == DONE);
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    next_state = (divisor == 4'h0) ? DONE : CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            CALC: begin
                if (count == 3'd0) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // busy/done are flopped from next_state so every output comes straight from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= 8'h00;
            remainder   <= 4'h0;
            div_by_zero <= 1'b0;
            partial_rem <= 5'd0;
            shift_dvd   <= 8'h00;
            count       <= 3'd0;
            divisor_r   <= 4'h0;
        end else begin
            busy <= (next_state == CALC);
            done <= (next_state == DONE);
            if (accept) begin
                divisor_r   <= divisor;
                shift_dvd   <= dividend;
                partial_rem <= 5'd0;
                count       <= 3'd7;
                if (divisor == 4'h0) begin
                    quotient    <= 8'hFF;
                    remainder   <= dividend[3:0];
                    div_by_zero <= 1'b1;
                end else begin
                    div_by_zero <= 1'b0;
                end
            end else if (state == CALC) begin
                partial_rem <= step_rem;
                shift_dvd   <= {shift_dvd[6:0], qbit};
                count       <= count - 3'd1;
                if (count == 3'd0) begin
                    quotient  <= {shift_dvd[6:0], qbit};
                    remainder <= step_rem[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_div_rem_4_bit.sv
// Self-checking bench for div_rem_4_bit: directed cases plus random operands checked
// against plain integer division.
module tb_div_rem_4_bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks;
    int errors;

    div_rem_4_bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done and busy must never overlap
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (done && busy) begin
                errors++;
                $display("[TB] FAIL handshake_overlap: done=%0b busy=%0b required not both high", done, busy);
            end
        end
    end

    // Called at a negedge: presents one request for one cycle, returns at the next negedge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Counts cycles since acceptance until done is seen; bounded.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [7:0] a, input logic [3:0] b,
                                input int lat, input int exp_lat);
        int eq;
        int er;
        logic edz;
        if (b == 0) begin
            eq = 255; er = int'(a[3:0]); edz = 1'b1;
        end else begin
            eq = int'(a) / int'(b); er = int'(a) % int'(b); edz = 1'b0;
        end
        checks++;
        if (lat !== exp_lat || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d (done=%0b) required %0d", name, lat, done, exp_lat);
        end
        checks++;
        if (int'(quotient) !== eq || int'(remainder) !== er || div_by_zero !== edz) begin
            errors++;
            $display("[TB] FAIL %s_result: %0d/%0d got q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b",
                     name, a, b, quotient, remainder, div_by_zero, eq, er, edz);
        end
        if (b != 0) begin
            checks++;
            if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || int'(remainder) >= int'(b)) begin
                errors++;
                $display("[TB] FAIL %s_identity: q=%0d r=%0d not exact for %0d/%0d",
                         name, quotient, remainder, a, b);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = 8'h00;
        divisor = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%0b done=%0b q=%0h r=%0h dbz=%0b required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%0b done=%0b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        issue(8'hC8, 4'h7);
        wait_done(lat, bc);
        check_result("basic_200_7", 8'hC8, 4'h7, lat, 9);
        checks++;
        if (bc != 8) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles: got %0d required 8", bc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 4'd4) begin
            errors++;
            $display("[TB] FAIL basic_hold: done=%0b q=%0d r=%0d required done=0 q=28 r=4", done, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(8'd255, 4'd1);
        wait_done(lat, bc);
        check_result("b2b_255_1", 8'd255, 4'd1, lat, 9);
        issue(8'd255, 4'd15);
        wait_done(lat, bc);
        check_result("b2b_255_15", 8'd255, 4'd15, lat, 9);
        @(negedge clk);
    endtask

    task automatic test_small();
        int lat, bc;
        issue(8'd5, 4'd9);
        wait_done(lat, bc);
        check_result("small_5_9", 8'd5, 4'd9, lat, 9);
        @(negedge clk);
        issue(8'd0, 4'd3);
        wait_done(lat, bc);
        check_result("small_0_3", 8'd0, 4'd3, lat, 9);
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        issue(8'h3C, 4'h0);
        wait_done(lat, bc);
        check_result("dbz_3c", 8'h3C, 4'h0, lat, 1);
        checks++;
        if (bc != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbz_busy: got busy_cycles=%0d busy=%0b required 0", bc, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL dbz_hold: done=%0b dbz=%0b q=%0h required 0 1 ff", done, div_by_zero, quotient);
        end
    endtask

    task automatic test_ignored_start();
        int lat, bc;
        issue(8'd100, 4'd3);
        @(negedge clk);
        dividend = 8'd77;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(lat, bc);
        check_result("ignored_start", 8'd100, 4'd3, lat + 2, 9);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignored_no_restart: busy=%0b done=%0b required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat, bc;
        int saw_done;
        issue(8'hC8, 4'h7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: busy=%0b done=%0b q=%0h r=%0h dbz=%0b required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw_done++;
        end
        checks++;
        if (saw_done != 0) begin
            errors++;
            $display("[TB] FAIL midreset_quiet: got %0d active cycles required 0", saw_done);
        end
        issue(8'd100, 4'd3);
        wait_done(lat, bc);
        check_result("post_reset", 8'd100, 4'd3, lat, 9);
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bc;
        logic [7:0] a;
        logic [3:0] b;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 4'($urandom);
            issue(a, b);
            wait_done(lat, bc);
            check_result("random", a, b, lat, (b == 0) ? 1 : 9);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_small();
        test_div_by_zero();
        test_ignored_start();
        test_reset_mid_calc();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
